// File: rtl/splash_scheduler.sv
// splash_scheduler: tracks up to NUM_SLOTS live splash animations, picks the
// splash covering the current pixel, steers its origin to the shared sprite
// ROM and realigns the hit flag with the ROM's two-cycle read latency.
module splash_scheduler #(
  parameter int          NUM_SLOTS         = 4,
  parameter int          SPRITE_W          = 50,
  parameter int          SPRITE_H          = 50,
  parameter int          LIFETIME_FRAMES   = 30,
  parameter logic [11:0] TRANSPARENT_COLOR = 12'h000
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 spawn_valid,
  input  logic [9:0]           spawn_x,
  input  logic [8:0]           spawn_y,
  output logic                 spawn_ready,
  input  logic                 frame_tick,
  input  logic [9:0]           x,
  input  logic [8:0]           y,
  output logic [9:0]           rom_x_org,
  output logic [8:0]           rom_y_org,
  input  logic [11:0]          rom_color,
  output logic [11:0]          pixel_out,
  output logic                 pixel_valid,
  output logic [NUM_SLOTS-1:0] active_mask
);

  localparam int         IDX_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [7:0] LIFE_INIT = 8'(LIFETIME_FRAMES);

  // Per-slot state
  logic [9:0]           r_sx   [NUM_SLOTS];
  logic [8:0]           r_sy   [NUM_SLOTS];
  logic [7:0]           r_life [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] r_active;

  // Hit-flag delay line matching the ROM (image RAM then palette RAM)
  logic                 r_hit_d1;
  logic                 r_hit_d2;
  logic [11:0]          r_pixel;
  logic                 r_pixel_vld;

  logic [NUM_SLOTS-1:0] w_hit;
  logic                 w_any_hit;
  logic [IDX_W-1:0]     w_win_idx;
  logic [IDX_W-1:0]     w_free_idx;
  logic                 w_spawn_fire;

  // Per-slot rectangle test; widened sums keep origins near the screen edge from wrapping
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_hit[i] = r_active[i]
        && ({1'b0, x} >= {1'b0, r_sx[i]})
        && ({1'b0, x} <= ({1'b0, r_sx[i]} + 11'(SPRITE_W - 1)))
        && ({1'b0, y} >= {1'b0, r_sy[i]})
        && ({1'b0, y} <= ({1'b0, r_sy[i]} + 10'(SPRITE_H - 1)));
    end
  end

  // Lowest-index hitting slot wins overlap; lowest-index free slot takes a spawn
  always_comb begin
    w_win_idx  = '0;
    w_free_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (w_hit[i])     w_win_idx  = IDX_W'(i);
      if (!r_active[i]) w_free_idx = IDX_W'(i);
    end
  end

  assign w_any_hit    = |w_hit;
  assign spawn_ready  = ~&r_active;
  assign w_spawn_fire = spawn_valid && spawn_ready;
  assign active_mask  = r_active;

  // With no hit the origin follows the pixel, so the ROM address stays at 0
  assign rom_x_org = w_any_hit ? r_sx[w_win_idx] : x;
  assign rom_y_org = w_any_hit ? r_sy[w_win_idx] : y;

  // Slot lifecycle: a spawn loads a free slot at full life; frame ticks age active slots
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_active <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) r_life[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (w_spawn_fire && (w_free_idx == IDX_W'(i))) begin
          r_sx[i]     <= spawn_x;
          r_sy[i]     <= spawn_y;
          r_life[i]   <= LIFE_INIT;
          r_active[i] <= 1'b1;
        end else if (frame_tick && r_active[i]) begin
          if (r_life[i] > 8'd1) begin
            r_life[i] <= r_life[i] - 8'd1;
          end else begin
            r_life[i]   <= '0;
            r_active[i] <= 1'b0;
          end
        end
      end
    end
  end

  // Delay the hit flag two cycles and gate the ROM colour into the output register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_hit_d1    <= 1'b0;
      r_hit_d2    <= 1'b0;
      r_pixel     <= '0;
      r_pixel_vld <= 1'b0;
    end else begin
      r_hit_d1    <= w_any_hit;
      r_hit_d2    <= r_hit_d1;
      r_pixel     <= r_hit_d2 ? rom_color : 12'h000;
      r_pixel_vld <= r_hit_d2 && (rom_color != TRANSPARENT_COLOR);
    end
  end

  assign pixel_out   = r_pixel;
  assign pixel_valid = r_pixel_vld;

endmodule
